trail_gen: RTL



---
 rtl/trail_gen_if.sv | 24 ++
 rtl/trail_gen.sv | 128 ++++++++++++
 2 files changed

// File: rtl/trail_gen_if.sv
// Handshake bundle between the game controller and the trail generator.
// The slave modport is the trail_gen side; the master modport is the controller side.
interface trail_gen_if #(
  parameter int TRAIL_LEN = 41
);
  logic                       frame_tick;
  logic [1:0]                 gamemode;
  logic [8:0]                 player_y;
  logic                       collide;
  logic [TRAIL_LEN-1:0][9:0]  trail_x;
  logic [TRAIL_LEN-1:0][8:0]  trail_y;
  logic [TRAIL_LEN-1:0][3:0]  trail_life;
  logic [5:0]                 active_count;

  modport master (
    output frame_tick, gamemode, player_y, collide,
    input  trail_x, trail_y, trail_life, active_count
  );

  modport slave (
    input  frame_tick, gamemode, player_y, collide,
    output trail_x, trail_y, trail_life, active_count
  );
endinterface

// File: rtl/trail_gen.sv
// Player motion-trail particle buffer: ages particles once per frame and spawns
// new ones at slot 0, so the newest particle always has draw priority.
module trail_gen #(
  parameter int TRAIL_LEN   = 41,
  parameter int LIFE_MAX    = 10,
  parameter int PLAYER_X    = 160,
  parameter int PLAYER_SIZE = 40,
  parameter int DRIFT       = 4,
  parameter int SPAWN_DIV   = 2
) (
  input  logic        clk,
  input  logic        rst,
  trail_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    GM_INIT  = 2'b00,
    GM_RUN   = 2'b01,
    GM_PAUSE = 2'b10,
    GM_END   = 2'b11
  } gamemode_e;

  localparam int              CNT_W      = (SPAWN_DIV > 1) ? $clog2(SPAWN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(1 % SPAWN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SPAWN_DIV - 1);
  localparam logic [9:0]      SPAWN_X    = 10'(PLAYER_X);
  localparam logic [8:0]      Y_OFF      = 9'(PLAYER_SIZE / 2);
  localparam logic [3:0]      LIFE_INIT  = 4'(LIFE_MAX);
  localparam logic [9:0]      DRIFT_X    = 10'(DRIFT);

  logic [TRAIL_LEN-1:0][9:0] x_q, x_d, aged_x;
  logic [TRAIL_LEN-1:0][8:0] y_q, y_d;
  logic [TRAIL_LEN-1:0][3:0] life_q, life_d, aged_life;
  logic [CNT_W-1:0]          spawn_cnt_q, spawn_cnt_d;
  logic                      burst_q, burst_d;
  logic [8:0]                spawn_y;
  logic                      spawn;
  gamemode_e                 gm;

  assign gm      = gamemode_e'(bus.gamemode);
  assign spawn_y = bus.player_y + Y_OFF;
  assign spawn   = (spawn_cnt_q == '0) || burst_q;

  // Aging: a particle that would drift past x = 0 is killed outright instead.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    aged_x    = x_q;
    aged_life = life_q;
    for (int k = 0; k < TRAIL_LEN; k++) begin
      if (life_q[k] != '0) begin
        if (x_q[k] < DRIFT_X) begin
          aged_x[k]    = '0;
          aged_life[k] = '0;
        end else begin
          aged_x[k]    = x_q[k] - DRIFT_X;
          aged_life[k] = life_q[k] - 4'd1;
        end
      end
    end
  end

  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    life_d      = life_q;
    spawn_cnt_d = spawn_cnt_q;
    burst_d     = burst_q;
    unique case (gm)
      GM_INIT: begin
        x_d         = '0;
        y_d         = '0;
        life_d      = '0;
        spawn_cnt_d = '0;
        burst_d     = 1'b0;
      end
      GM_RUN: begin
        if (bus.frame_tick) begin
          if (spawn) begin
            // Packed slot 0 is the LSB element, so concatenation shifts k into k+1.
            x_d         = {aged_x[TRAIL_LEN-2:0], SPAWN_X};
            y_d         = {y_q[TRAIL_LEN-2:0], spawn_y};
            life_d      = {aged_life[TRAIL_LEN-2:0], LIFE_INIT};
            spawn_cnt_d = CNT_RELOAD;
          end else begin
            x_d         = aged_x;
            life_d      = aged_life;
            spawn_cnt_d = (spawn_cnt_q == CNT_LAST) ? '0 : spawn_cnt_q + CNT_W'(1);
          end
          // A collide on the tick itself keeps the burst alive for the next tick.
          burst_d = bus.collide;
        end else begin
          burst_d = burst_q | bus.collide;
        end
      end
      default: burst_d = burst_q | bus.collide;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the particle arrays are reset because they drive the picture stage directly and must read as invisible.
      x_q         <= '0;
      y_q         <= '0;
      life_q      <= '0;
      spawn_cnt_q <= '0;
      burst_q     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      x_q         <= x_d;
      y_q         <= y_d;
      life_q      <= life_d;
      spawn_cnt_q <= spawn_cnt_d;
      burst_q     <= burst_d;
    end
  end

  always_comb begin
    bus.active_count = '0;
    for (int k = 0; k < TRAIL_LEN; k++) begin
      bus.active_count = bus.active_count + {5'd0, (life_q[k] != '0)};
    end
  end

  assign bus.trail_x    = x_q;
  assign bus.trail_y    = y_q;
  assign bus.trail_life = life_q;

endmodule
